// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and
// pointer code conversions used by both the write and read controllers.
package fifo_pkg;

  localparam int ADDR_DEF = 4;
  localparam int DEPTH    = 2 ** ADDR_DEF;
  localparam int PTR_W    = ADDR_DEF + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin[W-1] = gray[W-1];

  generate
    for (genvar gi = W - 2; gi >= 0; gi--) begin : g_prefix
      assign bin[gi] = bin[gi+1] ^ gray[gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: owns the write pointers
// and derives full / almost-full / level / overflow from the synced read pointer.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR         = ADDR_DEF,
  parameter int AFULL_THRESH = 2 ** ADDR - 2
) (
  input  logic            wr_clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [ADDR:0]   sync_rd_ptr,
  output logic            mem_wr_en,
  output logic [ADDR-1:0] wr_addr,
  output logic [ADDR:0]   gr_wr_ptr,
  output logic            wr_full,
  output logic            wr_almost_full,
  output logic [ADDR:0]   wr_level,
  output logic            wr_overflow
);

  localparam int PW = ADDR + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

  logic [PW-1:0] bin_reg, bin_next;
  logic [PW-1:0] gray_reg, gray_next;
  logic [PW-1:0] level_reg, level_next;
  logic [PW-1:0] rd_bin;
  logic          full_reg, full_next;
  logic          afull_reg, afull_next;
  logic          ovf_reg, ovf_next;
  logic          accept;

  fifo_gray2bin #(.W(PW)) u_rd_g2b (
    .gray (sync_rd_ptr),
    .bin  (rd_bin)
  );

  // Gated by reset too, so a push held during reset never reaches the memory.
  assign accept = wr_en & ~full_reg & rst;

  always_comb begin
    bin_next   = bin_reg + {{ADDR{1'b0}}, accept};
    gray_next  = bin_next ^ (bin_next >> 1);
    full_next  = (gray_next == {~sync_rd_ptr[ADDR:ADDR-1], sync_rd_ptr[ADDR-2:0]});
    level_next = bin_next - rd_bin;
    afull_next = (level_next >= AF_T);
    ovf_next   = wr_en & full_reg;
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      bin_reg   <= '0;
      gray_reg  <= '0;
      level_reg <= '0;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      bin_reg   <= bin_next;
      gray_reg  <= gray_next;
      level_reg <= level_next;
      full_reg  <= full_next;
      afull_reg <= afull_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign mem_wr_en      = accept;
  assign wr_addr        = bin_reg[ADDR-1:0];
  assign gr_wr_ptr      = gray_reg;
  assign wr_full        = full_reg;
  assign wr_almost_full = afull_reg;
  assign wr_level       = level_reg;
  assign wr_overflow    = ovf_reg;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with ADDR=4: a queue of expected post-edge
// results is filled as each cycle is driven and drained after the edge.
module tb_fifo_wr_ctrl;

  logic       wr_clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] sync_rd_ptr = '0;
  logic       mem_wr_en;
  logic [3:0] wr_addr;
  logic [4:0] gr_wr_ptr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [4:0] wr_level;
  logic       wr_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] gr;
    logic [4:0] lvl;
    logic       full;
    logic       af;
    logic       ovf;
    logic [3:0] addr;
  } exp_t;

  exp_t       q[$];
  logic [4:0] m_wr;
  logic [4:0] m_rd;
  logic       m_full;
  logic [4:0] prev_gr;

  fifo_wr_ctrl #(.ADDR(4), .AFULL_THRESH(14)) dut (
    .wr_clk         (wr_clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .sync_rd_ptr    (sync_rd_ptr),
    .mem_wr_en      (mem_wr_en),
    .wr_addr        (wr_addr),
    .gr_wr_ptr      (gr_wr_ptr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    logic [4:0] g;
    g[4] = b[4];
    for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gr"}, 32'(gr_wr_ptr), 0);
    chk({tag, "_lvl"}, 32'(wr_level), 0);
    chk({tag, "_full"}, 32'(wr_full), 0);
    chk({tag, "_af"}, 32'(wr_almost_full), 0);
    chk({tag, "_ovf"}, 32'(wr_overflow), 0);
    chk({tag, "_addr"}, 32'(wr_addr), 0);
  endtask

  // One wr_clk cycle: drive, predict, then compare after the edge.
  task automatic step(input logic we, input logic [4:0] rd_new);
    exp_t       e;
    exp_t       got;
    logic       acc;
    logic [4:0] lvl;
    @(negedge wr_clk);
    wr_en       = we;
    sync_rd_ptr = to_gray(rd_new);
    #1;
    acc = we & ~m_full;
    chk("mem_wr_en", 32'(mem_wr_en), 32'(acc));
    e.ovf   = we & m_full;
    m_wr    = m_wr + 5'(acc);
    m_rd    = rd_new;
    lvl     = m_wr - m_rd;
    m_full  = (lvl == 5'd16);
    e.gr    = to_gray(m_wr);
    e.lvl   = lvl;
    e.full  = m_full;
    e.af    = (lvl >= 5'd14);
    e.addr  = m_wr[3:0];
    q.push_back(e);
    prev_gr = gr_wr_ptr;
    @(posedge wr_clk);
    #1;
    got = q.pop_front();
    chk("gr_wr_ptr", 32'(gr_wr_ptr), 32'(got.gr));
    chk("wr_level", 32'(wr_level), 32'(got.lvl));
    chk("wr_full", 32'(wr_full), 32'(got.full));
    chk("wr_almost_full", 32'(wr_almost_full), 32'(got.af));
    chk("wr_overflow", 32'(wr_overflow), 32'(got.ovf));
    chk("wr_addr", 32'(wr_addr), 32'(got.addr));
    chk("gray_1bit", 32'($countones(gr_wr_ptr ^ prev_gr)), 32'(acc));
    $display("t=%0t we=%0b rd=%0d acc=%0b gr=%05b lvl=%0d full=%0b af=%0b ovf=%0b",
             $time, we, rd_new, acc, gr_wr_ptr, wr_level, wr_full, wr_almost_full, wr_overflow);
  endtask

  initial begin
    m_wr = '0; m_rd = '0; m_full = 1'b0; prev_gr = '0;

    // Push requested while held in reset: nothing may happen.
    wr_en = 1'b1;
    repeat (3) begin
      @(negedge wr_clk);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
      chk_all_zero("rst");
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
    rst   = 1'b1;

    repeat (10) step(1'b0, 5'd0);

    // Fill from empty; almost-full after 14, full after 16.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 5'd0);
      if (i == 13) chk("af_before_14", 32'(wr_almost_full), 0);
      if (i == 14) chk("af_at_14", 32'(wr_almost_full), 1);
      if (i == 15) chk("full_before_16", 32'(wr_full), 0);
    end
    chk("full_gr", 32'(gr_wr_ptr), 32'(5'b11000));
    chk("full_flag", 32'(wr_full), 1);

    // Rejected push: one-cycle overflow pulse, pointer holds.
    step(1'b1, 5'd0);
    chk("ovf_pulse", 32'(wr_overflow), 1);
    chk("ovf_gr_hold", 32'(gr_wr_ptr), 32'(5'b11000));
    step(1'b0, 5'd0);
    chk("ovf_cleared", 32'(wr_overflow), 0);

    // Reader advances to 4 (Gray 00110).
    step(1'b0, 5'd4);
    chk("drain_full", 32'(wr_full), 0);
    chk("drain_lvl", 32'(wr_level), 12);

    // Down to level 8, then push and read on the same edge.
    step(1'b0, 5'd8);
    step(1'b1, 5'd9);
    chk("simul_lvl", 32'(wr_level), 8);

    // Wrap: reader trails writer by 2 while 40 pushes cross 31 -> 0.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, m_wr - 5'd2);
      chk("wrap_no_full", 32'(wr_full), 0);
      if (m_wr == 5'd0) begin
        chk("wrap_prev_gr", 32'(prev_gr), 32'(5'b10000));
        chk("wrap_gr", 32'(gr_wr_ptr), 0);
      end
    end

    // Build level 9 then reset asynchronously mid-cycle.
    step(1'b0, m_wr);
    for (int i = 0; i < 9; i++) step(1'b1, m_rd);
    chk("pre_rst_lvl", 32'(wr_level), 9);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_mem_wr_en", 32'(mem_wr_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain control for the asynchronous FIFO. It owns the binary and Gray write pointers and produces the memory write strobe and address. It consumes the Gray read pointer already synchronised into wr_clk by sync_rd2wr, and from it derives full, almost-full, fill level and overflow. gr_wr_ptr feeds the write-to-read synchroniser.

Parameters:
ADDR, 4, address width; FIFO depth = 2**ADDR; pointers are ADDR+1 bits (extra wrap bit).
AFULL_THRESH, 2**ADDR-2, fill level at or above which wr_almost_full asserts; legal range 1..2**ADDR.

Ports:
wr_clk  input  1  write-domain clock.
rst  input  1  reset, asynchronous, active-low.
wr_en  input  1  push request from the producer.
sync_rd_ptr  input  ADDR+1  Gray read pointer, already synchronised to wr_clk.
mem_wr_en  output  1  memory write strobe; combinational, equals wr_en & ~wr_full.
wr_addr  output  ADDR  memory write address; the low ADDR bits of the binary write pointer.
gr_wr_ptr  output  ADDR+1  registered Gray write pointer, sent to the read-domain synchroniser.
wr_full  output  1  registered full flag.
wr_almost_full  output  1  registered; asserted when level >= AFULL_THRESH.
wr_level  output  ADDR+1  registered fill level, 0..2**ADDR.
wr_overflow  output  1  registered one-cycle pulse marking a push that was rejected while full.

Behaviour:
- Reset (rst low, asynchronous): clear all registers. Binary pointer, gr_wr_ptr, wr_full, wr_almost_full, wr_level and wr_overflow all read 0. wr_addr = 0. Registers are cleared mid-operation with no drain.
- Accept rule: accept = wr_en & ~wr_full. The memory writes data at wr_addr on the same wr_clk edge on which the pointer advances. Write latency is 0 cycles from request to strobe.
- Next-state values:
  - bin_next = bin + accept, modulo 2**(ADDR+1).
  - gray_next = bin_next ^ (bin_next >> 1).
  - On every edge: bin <= bin_next; gr_wr_ptr <= gray_next.
- Full: wr_full <= (gray_next == {~sync_rd_ptr[ADDR:ADDR-1], sync_rd_ptr[ADDR-2:0]}). It is recomputed every cycle, so it clears one edge after sync_rd_ptr advances.
- Level:
  - rbin = Gray-to-binary conversion of sync_rd_ptr.
  - level_next = (bin_next - rbin) modulo 2**(ADDR+1).
  - wr_level <= level_next.
  - wr_almost_full <= (level_next >= AFULL_THRESH).
- Pessimism: sync_rd_ptr lags the true read pointer by at least two cycles. full and level may therefore over-report occupancy but must never under-report it.
- Overflow: wr_overflow <= wr_en & wr_full. The pointer and memory are untouched on a rejected push, and no sticky state is kept.
- Wrap-around: the binary pointer wraps from 2**(ADDR+1)-1 to 0. The Gray pointer changes exactly one bit per accepted push, including across the wrap.
- Simultaneous events: a push accepted on the same edge that sync_rd_ptr advances uses both new values. In that case level is unchanged, and full is evaluated on the post-edge values.
- Gray pointer safety: gr_wr_ptr is driven directly from a register, with no combinational logic after the flop, so it is safe to sample from the other clock domain.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDR default;
  - depth constant;
  - pointer width constant;
  - bin2gray and gray2bin functions, shared with the read-side controller.
- One sub-module, fifo_gray2bin (parameterised by width, purely combinational XOR prefix), converts sync_rd_ptr to binary.
- Everything else stays in fifo_wr_ctrl.

Test Plan:
- Reset then idle, sync_rd_ptr=0 -> all outputs 0, wr_addr=0 for 10 cycles; wr_en=1 during reset -> no mem_wr_en.
- 16 back-to-back pushes, sync_rd_ptr=0, ADDR=4:
  - wr_almost_full rises after the 14th accept edge (wr_level=14);
  - wr_full rises after the 16th (wr_level=16, gr_wr_ptr=5'b11000, wr_addr=0).
- Push while full -> mem_wr_en=0, wr_overflow=1 for exactly one cycle, gr_wr_ptr holds 5'b11000.
- From full, set sync_rd_ptr=5'b00110 (binary 4) -> next edge: wr_full=0, wr_level=12, wr_almost_full=0.
- Simultaneous push and read advance, level 8 -> wr_level stays 8, pointers advance, no flag glitch.
- Wrap test with continuous reads (sync_rd_ptr tracking bin-2) over 40 pushes:
  - binary 31->0 transition gives gr_wr_ptr 5'b10000 -> 5'b00000;
  - checker confirms one-bit Gray change per accept and wr_full never asserts.
- Reset asserted mid-burst at level 9 -> all outputs 0 asynchronously, before the next wr_clk edge.
